fpga_pad_filter_bank: RTL
=========================

Name: fpga_pad_filter_bank

Overview:
Parametrised input-conditioning bank between FPGA IO buffers and the SoC pad ring. Per channel it provides:
- a synchroniser (SYNC_STAGES flops)
- a programmable debounce/glitch filter
- rise/fall edge event generation

It replaces the plain pass-through of pad inputs for asynchronous board signals (buttons, GPIO, external interrupts). One instance serves all N_IO pads.

Parameters:
N_IO, 48, number of pad channels
SYNC_STAGES, 2, synchroniser depth (legal range 2..4)
CNT_W, 8, width of debounce counter and threshold

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
pad_in_i  input  N_IO  raw asynchronous pad inputs
filt_en_i  input  N_IO  per-channel filter enable (quasi-static, clk_i domain)
debounce_cnt_i  input  CNT_W  global debounce threshold
pad_sync_o  output  N_IO  synchronised, unfiltered pad values
pad_filt_o  output  N_IO  filtered pad values
rise_o  output  N_IO  one-cycle pulse on 0->1 of pad_filt_o
fall_o  output  N_IO  one-cycle pulse on 1->0 of pad_filt_o
irq_o  output  1  OR-reduced event indication (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni. All flops clear to 0 immediately on rst_ni low.
- Reset values: pad_sync_o=0, pad_filt_o=0, rise_o=0, fall_o=0, irq_o=0, all counters=0.
- Synchroniser: pad_in_i passes through SYNC_STAGES flops; the last stage drives pad_sync_o. Latency is SYNC_STAGES cycles.
- Per-channel filter state: stable value s (drives pad_filt_o) and counter c[CNT_W-1:0].
- filt_en_i[i]=0 (bypass):
  - s <= sync each cycle, so pad_filt_o lags pad_sync_o by 1 cycle.
  - c <= 0.
- filt_en_i[i]=1:
  - If sync==s: c <= 0 (glitch discarded).
  - Else if c >= debounce_cnt_i: s <= sync and c <= 0.
  - Else: c <= c+1.
  - A new level is therefore accepted after debounce_cnt_i+1 consecutive differing cycles.
  - debounce_cnt_i=0 behaves identically to bypass.
- The ">=" compare covers a threshold lowered mid-count: acceptance happens on the next differing cycle.
- The counter cannot wrap: it is bounded by the threshold, and debounce_cnt_i max = 2^CNT_W-1.
- Enable toggled mid-count:
  - Disable: c clears and s follows sync next cycle.
  - Enable: counting starts from c=0.
- Edges: rise_o/fall_o are registered alongside s. rise_o[i]=1 in exactly the first cycle pad_filt_o[i] reads 1 after reading 0; fall_o symmetric. Never both high on one channel.
- Power-up edges: no spurious edges after reset release while pads are low. A pad held high at reset produces one rise_o pulse when s first updates to 1.
- Channel independence: channels are fully independent; simultaneous events on multiple channels are all reported in the same cycle.
- Total input-to-pad_filt_o latency: SYNC_STAGES + debounce_cnt_i + 1 cycles.

Optional Feature:
Macro: PAD_EVENT_LATCH_EN.
- Defined:
  - Adds ports evt_clr_i (input, N_IO) and evt_o (output, N_IO, reset 0).
  - evt_o[i] is sticky: set by rise_o[i]|fall_o[i], cleared by evt_clr_i[i].
  - Set wins over a simultaneous clear, so no event is lost.
  - irq_o = registered |evt_o.
- Not defined:
  - evt_clr_i and evt_o do not exist.
  - irq_o = registered |(rise_o|fall_o), i.e. a one-cycle pulse one cycle after the edge.

Test Plan:
1. Bypass, reset release, pad[3] 0->1 at cycle 10, filt_en=0, SYNC_STAGES=2 -> pad_sync_o[3]=1 at cycle 12, pad_filt_o[3]=1 and rise_o[3]=1 at cycle 13 for one cycle only.
2. Filter, filt_en[5]=1, debounce_cnt=4, 3-cycle high glitch on pad[5] -> pad_filt_o[5] stays 0, rise_o[5] never asserts, c returns to 0.
3. Filter acceptance, same setup with pad[5] held high for 20 cycles -> pad_filt_o[5] rises exactly 5 cycles after pad_sync_o[5]; high-to-low with the same threshold gives fall_o[5] after 5 cycles.
4. Multi-channel, pads 0, 17 and 47 toggle in the same cycle with mixed filt_en -> each channel's edge timing matches the single-channel model; irq_o asserts.
5. Reset mid-operation, rst_ni low while c[5]=3 and pad_filt_o=1 -> all outputs 0 asynchronously; after release with the pad still high, a single rise_o[5] follows the full debounce delay.
6. With PAD_EVENT_LATCH_EN, rise on pad[2] in the same cycle evt_clr_i[2]=1 -> evt_o[2]=1 and irq_o=1; a later clear without an event -> evt_o[2]=0 and irq_o=0 one cycle after.

Source files
------------

// File: rtl/fpga_pad_filter_bank.sv
// Pad input conditioning bank: synchroniser, debounce filter and edge events per channel.
// Optional sticky event latch with clear when PAD_EVENT_LATCH_EN is defined.
module fpga_pad_filter_bank #(
    parameter int N_IO        = 48,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_IO-1:0]  pad_in_i,
    input  logic [N_IO-1:0]  filt_en_i,
    input  logic [CNT_W-1:0] debounce_cnt_i,
`ifdef PAD_EVENT_LATCH_EN
    input  logic [N_IO-1:0]  evt_clr_i,
    output logic [N_IO-1:0]  evt_o,
`endif
    output logic [N_IO-1:0]  pad_sync_o,
    output logic [N_IO-1:0]  pad_filt_o,
    output logic [N_IO-1:0]  rise_o,
    output logic [N_IO-1:0]  fall_o,
    output logic             irq_o
);

    logic [N_IO-1:0] sync_q [SYNC_STAGES];
    logic [N_IO-1:0] sync_d [SYNC_STAGES];
    logic [N_IO-1:0] sync_w;
    logic [N_IO-1:0] filt_w;
    logic [N_IO-1:0] rise_w;
    logic [N_IO-1:0] fall_w;
    logic            irq_q;
    logic            irq_d;

    always_comb begin
        sync_d[0] = pad_in_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < N_IO; gi++) begin : g_ch
            logic             s_q, s_d;
            logic             rise_q, rise_d;
            logic             fall_q, fall_d;
            logic [CNT_W-1:0] c_q, c_d;

            // Counter only advances while below threshold, so it can never wrap.
            always_comb begin
                s_d = s_q;
                c_d = '0;
                if (!filt_en_i[gi]) begin
                    s_d = sync_w[gi];
                end else if (sync_w[gi] != s_q) begin
                    if (c_q >= debounce_cnt_i) begin
                        s_d = sync_w[gi];
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
                rise_d = s_d & ~s_q;
                fall_d = ~s_d & s_q;
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    s_q    <= 1'b0;
                    c_q    <= '0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    s_q    <= s_d;
                    c_q    <= c_d;
                    rise_q <= rise_d;
                    fall_q <= fall_d;
                end
            end

            assign filt_w[gi] = s_q;
            assign rise_w[gi] = rise_q;
            assign fall_w[gi] = fall_q;
        end
    endgenerate

`ifdef PAD_EVENT_LATCH_EN
    logic [N_IO-1:0] evt_q, evt_d;

    // A new edge wins over a simultaneous clear so no event is dropped.
    always_comb begin
        evt_d = (evt_q & ~evt_clr_i) | rise_w | fall_w;
        irq_d = |evt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_o = evt_q;
`else
    always_comb begin
        irq_d = |(rise_w | fall_w);
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign pad_sync_o = sync_w;
    assign pad_filt_o = filt_w;
    assign rise_o     = rise_w;
    assign fall_o     = fall_w;
    assign irq_o      = irq_q;

endmodule
